// File: rtl/ej32_pkg.sv
// ej32 shared definitions used by the divide sequencer.
//   div_state_t : divider FSM states
//   div_op_t    : which result the divider returns (quotient or remainder)
//   div_cnt_w   : width of an iteration counter that must count 0..steps-1
package ej32_pkg;

  localparam int DSZ_DEF   = 32;
  localparam int BPC_DEF   = 1;
  localparam int DIV_STEPS = DSZ_DEF / BPC_DEF;

  typedef enum logic [1:0] {dIDLE, dCALC, dFIX, dDONE} div_state_t;
  typedef enum logic {DIV_Q, DIV_R} div_op_t;

  function automatic int div_cnt_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/ej32_div_step.sv
// One restoring-division step, purely combinational.
//   rem_i/rem_o : partial remainder in/out (DSZ+1 bits)
//   quo_i/quo_o : shift register; dividend bits leave at the MSB while
//                 quotient bits enter at the LSB
//   dsr_i       : divisor magnitude
module ej32_div_step #(
  parameter int DSZ = 32
) (
  input  logic [DSZ:0]   rem_i,
  input  logic [DSZ-1:0] quo_i,
  input  logic [DSZ-1:0] dsr_i,
  output logic [DSZ:0]   rem_o,
  output logic [DSZ-1:0] quo_o
);

  logic [DSZ+1:0] shl;
  logic [DSZ+1:0] dif;
  logic           borrow;

  always_comb begin
    shl = {rem_i, quo_i[DSZ-1]};
    // One extra bit on top of the remainder width: its sign is the borrow,
    // so the trial subtract doubles as the compare.
    dif    = shl - {2'b00, dsr_i};
    borrow = dif[DSZ+1];
    if (borrow) begin
      rem_o = shl[DSZ:0];
      quo_o = {quo_i[DSZ-2:0], 1'b0};
    end else begin
      rem_o = dif[DSZ:0];
      quo_o = {quo_i[DSZ-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ej32_div_seq.sv
// Multi-cycle signed divider for idiv/irem with Java semantics.
// Operands are captured on an accepted start, divided as unsigned magnitudes
// (BPC quotient bits per CALC cycle), then sign-corrected in FIX.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, honoured only in IDLE or DONE
//   op        : 0 = quotient, 1 = remainder
//   dividend  : NOS, two's complement
//   divisor   : TOS, two's complement
//   div_bsy   : high while CALC/FIX run (stack pop must stall)
//   done      : high for the single DONE cycle
//   result    : quotient or remainder, held until the next commit
//   dz        : divide-by-zero flag, same timing as result
module ej32_div_seq
  import ej32_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int BPC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic signed [DSZ-1:0] dividend,
  input  logic signed [DSZ-1:0] divisor,
  output logic                  div_bsy,
  output logic                  done,
  output logic [DSZ-1:0]        result,
  output logic                  dz
);

  localparam int STEPS = DSZ / BPC;
  localparam int CW    = div_cnt_w(STEPS);

  div_state_t     state_q, state_d;
  logic           bsy_q, done_q, dz_q;
  logic [DSZ-1:0] res_q;
  logic [DSZ:0]   rem_q;
  logic [DSZ-1:0] quo_q;
  logic [DSZ-1:0] dsr_q;
  logic           sq_q, sr_q;
  div_op_t        op_q;
  logic [CW-1:0]  cnt_q;

  logic           acc;
  logic           dsr_zero;
  logic [DSZ:0]   rem_c [0:BPC];
  logic [DSZ-1:0] quo_c [0:BPC];

  // Two's complement negate when n is set; wraps modulo 2^DSZ, which is
  // exactly what makes MIN/-1 = MIN and MIN rem -1 = 0.
  function automatic logic [DSZ-1:0] cneg(input logic [DSZ-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Unsigned magnitude; |MIN| = 2^(DSZ-1) still fits in DSZ unsigned bits.
  function automatic logic [DSZ-1:0] mag(input logic signed [DSZ-1:0] x);
    logic [DSZ-1:0] u;
    u = x;
    return cneg(u, x[DSZ-1]);
  endfunction

  assign acc      = start && ((state_q == dIDLE) || (state_q == dDONE));
  assign dsr_zero = (divisor == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      dIDLE: begin
        if (start) state_d = dsr_zero ? dDONE : dCALC;
      end
      dCALC: begin
        if (cnt_q == CW'(STEPS - 1)) state_d = dFIX;
      end
      dFIX: state_d = dDONE;
      dDONE: begin
        if (start) state_d = dsr_zero ? dDONE : dCALC;
        else       state_d = dIDLE;
      end
    endcase
  end

  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;

  for (genvar g = 0; g < BPC; g++) begin : g_step
    ej32_div_step #(.DSZ(DSZ)) u_step (
      .rem_i (rem_c[g]),
      .quo_i (quo_c[g]),
      .dsr_i (dsr_q),
      .rem_o (rem_c[g+1]),
      .quo_o (quo_c[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= dIDLE;
      bsy_q   <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      op_q    <= DIV_Q;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Outputs follow the next state so they line up with state_q.
      bsy_q   <= (state_d == dCALC) || (state_d == dFIX);
      done_q  <= (state_d == dDONE);
      if (acc) begin
        quo_q <= mag(dividend);
        dsr_q <= mag(divisor);
        rem_q <= '0;
        cnt_q <= '0;
        sq_q  <= dividend[DSZ-1] ^ divisor[DSZ-1];
        sr_q  <= dividend[DSZ-1];
        op_q  <= div_op_t'(op);
        if (dsr_zero) begin
          res_q <= '0;
          dz_q  <= 1'b1;
        end
      end else if (state_q == dCALC) begin
        rem_q <= rem_c[BPC];
        quo_q <= quo_c[BPC];
        cnt_q <= cnt_q + CW'(1);
      end else if (state_q == dFIX) begin
        // After the last step quo_q holds Q and rem_q holds R.
        res_q <= (op_q == DIV_R) ? cneg(rem_q[DSZ-1:0], sr_q) : cneg(quo_q, sq_q);
        dz_q  <= 1'b0;
      end
    end
  end

  assign div_bsy = bsy_q;
  assign done    = done_q;
  assign result  = res_q;
  assign dz      = dz_q;

endmodule
